mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 151 +++++++++++++++
 tb/tb_mult_div.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional divider: define MULT_DIV_DIVIDE_EN to enable div/divu (otherwise they are no-ops).
module mult_div #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_NONE7 = 3'b111
  } mdop_e;

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_res_hi;
  logic [31:0]      r_res_lo;
  logic             r_wr;

  logic             w_accept;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_res_wr;
  logic             w_mthi;
  logic             w_mtlo;

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;

  assign w_sprod = $signed(A) * $signed(B);
  assign w_uprod = {32'd0, A} * {32'd0, B};

`ifdef MULT_DIV_DIVIDE_EN
  logic               w_div_ovf;
  logic signed [31:0] w_sb_safe;
  logic        [31:0] w_ub_safe;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic        [31:0] w_uq;
  logic        [31:0] w_ur;

  // A divisor of 1 for 0x80000000 / -1 yields exactly q=0x80000000, r=0 without overflow.
  assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_sb_safe = (w_div_ovf || (B == 32'd0)) ? 32'sd1 : $signed(B);
  assign w_ub_safe = (B == 32'd0) ? 32'd1 : B;
  assign w_sq      = $signed(A) / w_sb_safe;
  assign w_sr      = $signed(A) % w_sb_safe;
  assign w_uq      = A / w_ub_safe;
  assign w_ur      = A % w_ub_safe;
`endif

  assign w_accept = start && !busy;

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_res_hi   = r_res_hi;
    w_res_lo   = r_res_lo;
    w_res_wr   = r_wr;
    w_mthi     = 1'b0;
    w_mtlo     = 1'b0;
    case (mdop_e'(MDop))
      OP_MULT: begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(MULT_CYCLES);
        w_res_hi   = w_sprod[63:32];
        w_res_lo   = w_sprod[31:0];
        w_res_wr   = 1'b1;
      end
      OP_MULTU: begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(MULT_CYCLES);
        w_res_hi   = w_uprod[63:32];
        w_res_lo   = w_uprod[31:0];
        w_res_wr   = 1'b1;
      end
`ifdef MULT_DIV_DIVIDE_EN
      OP_DIV: begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(DIV_CYCLES);
        w_res_hi   = w_sr;
        w_res_lo   = w_sq;
        w_res_wr   = (B != 32'd0);
      end
      OP_DIVU: begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(DIV_CYCLES);
        w_res_hi   = w_ur;
        w_res_lo   = w_uq;
        w_res_wr   = (B != 32'd0);
      end
`endif
      OP_MTHI: w_mthi = 1'b1;
      OP_MTLO: w_mtlo = 1'b1;
      default: ;
    endcase
  end

  // Acceptance is only possible while idle, so it never collides with a completion write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_wr     <= 1'b0;
    end else begin
      if (w_accept && w_load) begin
        r_cnt    <= w_load_val;
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
        r_wr     <= w_res_wr;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if ((r_cnt == CNT_W'(1)) && r_wr) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
      if (w_accept && w_mthi) r_hi <= A;
      if (w_accept && w_mtlo) r_lo <= A;
    end
  end

  assign busy = (r_cnt != '0);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: cycle model plus directed literal checks.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  MDop = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int failures = 0;

  mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDop(MDop),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted long op keeps busy for N cycles, then its result lands.
  int          m_left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;

  always @(posedge clk or negedge rst_n) begin
    longint sa, sb, ua, ub;
    logic [63:0] prod;
    if (!rst_n) begin
      m_left = 0; m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0;
    end else if (m_left != 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      sa = longint'($signed(A)); sb = longint'($signed(B));
      ua = longint'({32'd0, A}); ub = longint'({32'd0, B});
      case (MDop)
        3'd1: begin prod = 64'(sa * sb); p_hi = prod[63:32]; p_lo = prod[31:0]; p_wr = 1; m_left = 5; end
        3'd2: begin prod = 64'(ua * ub); p_hi = prod[63:32]; p_lo = prod[31:0]; p_wr = 1; m_left = 5; end
`ifdef MULT_DIV_DIVIDE_EN
        3'd3: begin
          m_left = 10; p_wr = (B != 0);
          if (B != 0) begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
        end
        3'd4: begin
          m_left = 10; p_wr = (B != 0);
          if (B != 0) begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
        end
`endif
        3'd5: m_hi = A;
        3'd6: m_lo = A;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    checks = checks + 1;
    if (busy !== (m_left != 0) || HI !== m_hi || LO !== m_lo) begin
      failures = failures + 1;
      $display("FAIL model_cmp t=%0t busy=%b HI=%h LO=%h required busy=%b HI=%h LO=%h",
               $time, busy, HI, LO, (m_left != 0), m_hi, m_lo);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; MDop = op; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; MDop = 3'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
  endtask

  int n;
  logic [31:0] sv_hi, sv_lo;
  int exp_div_cyc;

  initial begin
`ifdef MULT_DIV_DIVIDE_EN
    exp_div_cyc = 10;
`else
    exp_div_cyc = 0;
`endif
    #1;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // signed multiply
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("mult_cycles", n, 5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    // unsigned multiply
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("multu_cycles", n, 5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // mthi / mtlo write at acceptance with no busy
    issue(3'd5, 32'h0000_1234, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'h0);
    chk("mthi_hi", HI, 32'h0000_1234);
    issue(3'd6, 32'h0000_0055, 32'd0);
    chk("mtlo_lo", LO, 32'h0000_0055);

    // signed divide -7 / 2
    sv_hi = HI; sv_lo = LO;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", n, exp_div_cyc);
`ifdef MULT_DIV_DIVIDE_EN
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'h0);
`else
    chk("div_off_lo", LO, sv_lo);
    chk("div_off_hi", HI, sv_hi);
`endif

    // start during busy is ignored
    issue(3'd1, 32'h0001_0000, 32'h0003_0000);
    @(posedge clk); #2;
    issue(3'd5, 32'h0000_1234, 32'd0);
    wait_idle(n);
    chk("reject_hi", HI, 32'h0000_0003);
    chk("reject_lo", LO, 32'h0);

    // back-to-back: command held high is taken at the first idle edge
    issue(3'd1, 32'd2, 32'd3);
    A = 32'h77; MDop = 3'd6; start = 1'b1;
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #2; n++; end
    @(posedge clk); #2;
    start = 1'b0; MDop = 3'd0;
    chk("b2b_lo", LO, 32'h77);
    chk("b2b_hi", HI, 32'h0);

    // no-op encodings
    sv_hi = HI; sv_lo = LO;
    issue(3'd0, 32'hDEAD_BEEF, 32'd1);
    chk("nop0_busy", {31'd0, busy}, 32'h0);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    chk("nop7_hi", HI, sv_hi);
    chk("nop7_lo", LO, sv_lo);

    // divide by zero leaves HI/LO untouched
    issue(3'd6, 32'hAA, 32'd0);
    issue(3'd5, 32'h5, 32'd0);
    issue(3'd4, 32'd100, 32'd0);
    wait_idle(n);
    chk("div0_cycles", n, exp_div_cyc);
    chk("div0_lo", LO, 32'hAA);
    chk("div0_hi", HI, 32'h5);

    // reset mid divu aborts it
    issue(3'd4, 32'd100, 32'd7);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", HI, 32'h0);
    chk("rst_mid_lo", LO, 32'h0);
    chk("rst_mid_busy", {31'd0, busy}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    issue(3'd6, 32'h0000_0042, 32'd0);
    chk("post_rst_accept", LO, 32'h42);
    repeat (14) @(posedge clk);
    #2;
    chk("post_rst_hi", HI, 32'h0);
    chk("post_rst_lo", LO, 32'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
